// File: rtl/ram_bus_arbiter_pkg.sv
// Shared types and helpers for the SRAM bus arbiter and its round-robin picker.
package ram_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Bit offset of channel ch inside a packed per-channel vector.
    function automatic int ch_slice(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/ram_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after ptr (wrapping), with
// optional absolute priority for channel 0.
module rr_picker #(
    parameter int NUM_CH       = 3,
    parameter int CH0_PRIORITY = 1,
    localparam int IW          = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IW-1:0]     ptr,
    output logic              valid,
    output logic [IW-1:0]     idx
);

    int          cand;
    logic [IW-1:0] cand_idx;

    always_comb begin
        valid    = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        if (CH0_PRIORITY != 0 && req[0]) begin
            valid = 1'b1;
        end else begin
            for (int i = 1; i <= NUM_CH; i++) begin
                cand = int'(ptr) + i;
                if (cand >= NUM_CH) cand = cand - NUM_CH;
                cand_idx = IW'(cand);
                if (!valid && req[cand_idx]) begin
                    valid = 1'b1;
                    idx   = cand_idx;
                end
            end
        end
    end

endmodule

// File: rtl/ram_bus_arbiter.sv
// N-channel SRAM access arbiter: one access at a time through
// IDLE -> SETUP -> STROBE (STROBE_CYCLES) -> HOLD, all pin outputs registered.
module ram_bus_arbiter
    import ram_bus_arbiter_pkg::*;
#(
    parameter int NUM_CH        = 3,
    parameter int ADDR_WIDTH    = 17,
    parameter int DATA_WIDTH    = 8,
    parameter int STROBE_CYCLES = 3,
    parameter int CH0_PRIORITY  = 1,
    localparam int IW           = $clog2(NUM_CH)
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic [NUM_CH-1:0]            ch_req_i,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata_i,
    input  logic [NUM_CH-1:0]            ch_we_n_i,
    output logic [NUM_CH-1:0]            ch_ack_o,
    output logic [DATA_WIDTH-1:0]        rdata_o,
    output logic [IW-1:0]                grant_o,
    output logic                         busy_o,
    output logic [ADDR_WIDTH-1:0]        ram_addr_o,
    output logic [DATA_WIDTH-1:0]        ram_data_o,
    output logic                         ram_data_oe_o,
    input  logic [DATA_WIDTH-1:0]        ram_data_i,
    output logic                         ram_oe_n_o,
    output logic                         ram_we_n_o
);

    localparam int CW = $clog2(STROBE_CYCLES + 1);

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   ptr;
    logic            we_n_lat;
    logic            we_n_next;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_CH];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_CH];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign addr_arr[k]  = ch_addr_i[ch_slice(k, ADDR_WIDTH) +: ADDR_WIDTH];
        assign wdata_arr[k] = ch_wdata_i[ch_slice(k, DATA_WIDTH) +: DATA_WIDTH];
    end

    rr_picker #(
        .NUM_CH       (NUM_CH),
        .CH0_PRIORITY (CH0_PRIORITY)
    ) u_picker (
        .req   (ch_req_i),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = SETUP;
            SETUP:   state_next = STROBE;
            STROBE:  if (cnt <= CW'(1)) state_next = HOLD;
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The winner's we_n is needed one edge before it lands in we_n_lat.
    assign we_n_next = (state == IDLE) ? ch_we_n_i[pick_idx] : we_n_lat;
    assign busy_o    = (state != IDLE);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state         <= IDLE;
            cnt           <= '0;
            ptr           <= IW'(NUM_CH - 1);
            we_n_lat      <= 1'b1;
            grant_o       <= '0;
            ram_addr_o    <= '0;
            ram_data_o    <= '0;
            rdata_o       <= '0;
            ram_oe_n_o    <= 1'b1;
            ram_we_n_o    <= 1'b1;
            ram_data_oe_o <= 1'b0;
            ch_ack_o      <= '0;
        end else begin
            state         <= state_next;
            ram_oe_n_o    <= !(state_next == STROBE && we_n_lat);
            ram_we_n_o    <= !(state_next == STROBE && !we_n_lat);
            ram_data_oe_o <= (state_next != IDLE) && !we_n_next;
            ch_ack_o      <= '0;
            if (state_next == HOLD) ch_ack_o[grant_o] <= 1'b1;

            if (state == IDLE && pick_valid) begin
                grant_o    <= pick_idx;
                ram_addr_o <= addr_arr[pick_idx];
                ram_data_o <= wdata_arr[pick_idx];
                we_n_lat   <= ch_we_n_i[pick_idx];
            end

            if (state == SETUP) begin
                cnt <= CW'(STROBE_CYCLES);
            end else if (state == STROBE && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            if (state == STROBE && cnt == CW'(1) && we_n_lat) rdata_o <= ram_data_i;
            if (state == HOLD) ptr <= grant_o;
        end
    end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter: directed timing checks, contention, reset mid-access,
// a wide/short-strobe instance, and a random phase against an arbitration model.
module tb_ram_bus_arbiter;

    localparam int AW = 17;
    localparam int DW = 8;
    localparam int S  = 3;

    int tests = 0;
    int fails = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // default instance (3 channels, strobe 3, ch0 priority)
    logic [2:0]      req = '0, we_bus = '1;
    logic [3*AW-1:0] addr_bus = '0;
    logic [3*DW-1:0] wdata_bus = '0;
    logic [2:0]      ack;
    logic [DW-1:0]   rdata, ram_dout, ram_din;
    logic [1:0]      grant;
    logic            busy, data_oe, oe_n, ram_we;
    logic [AW-1:0]   ram_addr;
    logic [7:0]      mem [0:(1<<AW)-1];
    logic [7:0]      shadow [int];

    assign ram_din = !oe_n ? mem[ram_addr] : 8'h00;
    always @(posedge clk) if (!ram_we && data_oe) mem[ram_addr] <= ram_dout;

    ram_bus_arbiter dut (
        .clock_i(clk), .reset_i(rst), .ch_req_i(req), .ch_addr_i(addr_bus),
        .ch_wdata_i(wdata_bus), .ch_we_n_i(we_bus), .ch_ack_o(ack), .rdata_o(rdata),
        .grant_o(grant), .busy_o(busy), .ram_addr_o(ram_addr), .ram_data_o(ram_dout),
        .ram_data_oe_o(data_oe), .ram_data_i(ram_din), .ram_oe_n_o(oe_n), .ram_we_n_o(ram_we)
    );

    // pure round-robin instance
    logic [2:0]      req_r = '0;
    logic [2:0]      ack_r;
    logic [1:0]      grant_r;
    logic [DW-1:0]   rdata_r, dout_r;
    logic [AW-1:0]   addr_r;
    logic            busy_r, doe_r, oe_r, we_r;

    ram_bus_arbiter #(.CH0_PRIORITY(0)) dut_rr (
        .clock_i(clk), .reset_i(rst), .ch_req_i(req_r), .ch_addr_i({3*AW{1'b0}}),
        .ch_wdata_i({3*DW{1'b0}}), .ch_we_n_i(3'b111), .ch_ack_o(ack_r), .rdata_o(rdata_r),
        .grant_o(grant_r), .busy_o(busy_r), .ram_addr_o(addr_r), .ram_data_o(dout_r),
        .ram_data_oe_o(doe_r), .ram_data_i(8'h00), .ram_oe_n_o(oe_r), .ram_we_n_o(we_r)
    );

    // 8-channel, single-cycle strobe instance
    logic [7:0]      req8 = '0;
    logic [8*AW-1:0] addr8 = '0;
    logic [7:0]      ack8;
    logic [2:0]      grant8;
    logic [DW-1:0]   rdata8, dout8, din8;
    logic [AW-1:0]   raddr8;
    logic            busy8, doe8, oe8, we8;

    assign din8 = raddr8[7:0] ^ 8'hC3;

    ram_bus_arbiter #(.NUM_CH(8), .STROBE_CYCLES(1)) dut8 (
        .clock_i(clk), .reset_i(rst), .ch_req_i(req8), .ch_addr_i(addr8),
        .ch_wdata_i({8*DW{1'b0}}), .ch_we_n_i(8'hFF), .ch_ack_o(ack8), .rdata_o(rdata8),
        .grant_o(grant8), .busy_o(busy8), .ram_addr_o(raddr8), .ram_data_o(dout8),
        .ram_data_oe_o(doe8), .ram_data_i(din8), .ram_oe_n_o(oe8), .ram_we_n_o(we8)
    );

    int both_low = 0, we_no_oe = 0;
    always @(negedge clk) if (!rst) begin
        if (!oe_n && !ram_we) both_low++;
        if (!ram_we && !data_oe) we_no_oe++;
        if (!oe_r && !we_r) both_low++;
        if (!oe8 && !we8) both_low++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [7:0] init_val(input logic [16:0] a);
        return a[7:0] ^ a[15:8] ^ {7'b0, a[16]} ^ 8'h3C;
    endfunction

    function automatic logic [7:0] model_mem(input logic [16:0] a);
        if (shadow.exists(int'(a))) return shadow[int'(a)];
        return init_val(a);
    endfunction

    task automatic set_ch(input int ch, input logic r, input logic [16:0] a,
                          input logic [7:0] d, input logic wn);
        req[ch]                 = r;
        addr_bus[ch*AW +: AW]   = a;
        wdata_bus[ch*DW +: DW]  = d;
        we_bus[ch]              = wn;
    endtask

    // Steps until the default instance acks (at least one step); returns cycles taken.
    task automatic wait_ack(input string tag, output int n);
        n = 0;
        do begin step(); n++; end while (ack == 3'b000 && n < 40);
        check({tag, "_ack_seen"}, 32'(ack != 3'b000), 32'd1);
    endtask

    // One isolated access on the default instance with a per-cycle pin timing check.
    task automatic run_single(input int ch, input logic [16:0] a, input logic [7:0] d,
                              input logic wn, input string tag);
        logic strobe;
        set_ch(ch, 1'b1, a, d, wn);
        for (int j = 1; j <= S + 3; j++) begin
            step();
            strobe = (j >= 2 && j <= S + 1);
            check({tag, "_oe_n"},    32'(oe_n),    32'(!(strobe && wn)));
            check({tag, "_we_n"},    32'(ram_we),  32'(!(strobe && !wn)));
            check({tag, "_data_oe"}, 32'(data_oe), 32'(!wn && j <= S + 2));
            check({tag, "_ack"},     32'(ack),     (j == S + 2) ? (32'd1 << ch) : 32'd0);
            check({tag, "_busy"},    32'(busy),    32'(j <= S + 2));
            if (j == 1) begin
                check({tag, "_addr"},  32'(ram_addr), 32'(a));
                check({tag, "_grant"}, 32'(grant),    32'(ch));
            end
            if (j == S + 2) begin
                req[ch] = 1'b0;
                if (wn) check({tag, "_rdata"}, 32'(rdata), 32'(model_mem(a)));
            end
        end
        if (!wn) begin
            check({tag, "_mem"}, 32'(mem[a]), 32'(d));
            shadow[int'(a)] = d;
        end
    endtask

    // Random-phase model state
    bit            pend [3];
    logic [16:0]   pa   [3];
    logic [7:0]    pd   [3];
    bit            pw   [3];
    int            last;

    function automatic int model_pick();
        if (pend[0]) return 0;
        for (int i = 1; i <= 3; i++) if (pend[(last + i) % 3]) return (last + i) % 3;
        return -1;
    endfunction

    initial begin
        int n, t, p;
        int seq_pr [7] = '{0, 0, 0, 1, 2, 1, 2};

        for (int i = 0; i < (1 << AW); i++) mem[i] = init_val(17'(i));

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_oe_n", 32'(oe_n), 32'd1);
        check("rst_we_n", 32'(ram_we), 32'd1);
        check("rst_data_oe", 32'(data_oe), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_wdata", 32'(ram_dout), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        rst = 1'b0;
        step();

        mem[17'h0_4000] = 8'hA5;
        shadow[int'(17'h0_4000)] = 8'hA5;
        run_single(1, 17'h0_4000, 8'h00, 1'b1, "read1");
        check("read1_rdata_A5", 32'(rdata), 32'hA5);

        run_single(2, 17'h1_8000, 8'h01, 1'b0, "write2");
        run_single(0, 17'h1_8000, 8'h00, 1'b1, "readback");
        check("readback_01", 32'(rdata), 32'h01);

        for (int c = 0; c < 3; c++) set_ch(c, 1'b1, 17'(c * 16), 8'h00, 1'b1);
        for (int k = 0; k < 7; k++) begin
            wait_ack("prio", n);
            check("prio_ack", 32'(ack), 32'd1 << seq_pr[k]);
            check("prio_grant", 32'(grant), 32'(seq_pr[k]));
            if (k == 2) req[0] = 1'b0;
        end
        req = '0;
        step();

        // reset in the second STROBE cycle of a write
        set_ch(2, 1'b1, 17'h0_1234, 8'h77, 1'b0);
        repeat (3) step();
        check("rst_mid_we_low", 32'(ram_we), 32'd0);
        rst = 1'b1;
        req[2] = 1'b0;
        step();
        check("rst_mid_we_n", 32'(ram_we), 32'd1);
        check("rst_mid_data_oe", 32'(data_oe), 32'd0);
        check("rst_mid_ack", 32'(ack), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        shadow[int'(17'h0_1234)] = 8'h77;
        step();
        run_single(0, 17'h0_0042, 8'h00, 1'b1, "post_rst");

        // round-robin instance: all three request continuously
        req_r = 3'b111;
        t = 0;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            do begin step(); n++; end while (ack_r == 3'b000 && n < 40);
            check("rr_ack", 32'(ack_r), 32'd1 << (k % 3));
            check("rr_grant", 32'(grant_r), 32'(k % 3));
            check("rr_spacing", 32'(n), (k == 0) ? 32'(S + 2) : 32'(S + 3));
        end
        req_r = '0;
        step();

        // 8-channel instance, single-cycle strobe
        addr8[3*AW +: AW] = 17'h0_0055;
        req8[3] = 1'b1;
        n = 0;
        do begin step(); n++; end while (ack8 == 8'h00 && n < 40);
        check("w8_latency", 32'(n), 32'd3);
        check("w8_ack3", 32'(ack8), 32'h08);
        check("w8_rdata", 32'(rdata8), 32'(8'h55 ^ 8'hC3));
        req8 = '0;
        req8[6] = 1'b1;
        n = 0;
        do begin step(); n++; end while (ack8 == 8'h00 && n < 40);
        check("w8_ack6", 32'(ack8), 32'h40);
        req8 = 8'b1000_0010;
        n = 0;
        do begin step(); n++; end while (ack8 == 8'h00 && n < 40);
        check("w8_wrap_ack7", 32'(ack8), 32'h80);
        check("w8_wrap_grant7", 32'(grant8), 32'd7);
        req8[7] = 1'b0;
        n = 0;
        do begin step(); n++; end while (ack8 == 8'h00 && n < 40);
        check("w8_wrap_ack1", 32'(ack8), 32'h02);
        req8 = '0;

        // random phase against the arbitration/memory model
        rst = 1'b1;
        step();
        rst = 1'b0;
        last = 2;
        for (int c = 0; c < 3; c++) pend[c] = 0;
        for (int it = 0; it < 40; it++) begin
            for (int c = 0; c < 3; c++) begin
                if (!pend[c] && $urandom_range(0, (c == 0) ? 3 : 1) == 0) begin
                    pend[c] = 1;
                    pa[c] = 17'($urandom_range(0, 47)) | (($urandom_range(0, 1) == 1) ? 17'h1_0000 : 17'h0);
                    pd[c] = 8'($urandom_range(0, 255));
                    pw[c] = ($urandom_range(0, 1) == 1);
                    set_ch(c, 1'b1, pa[c], pd[c], pw[c]);
                end
            end
            if (!pend[0] && !pend[1] && !pend[2]) begin
                p = $urandom_range(1, 2);
                pend[p] = 1;
                pa[p] = 17'($urandom_range(0, 47));
                pd[p] = 8'($urandom_range(0, 255));
                pw[p] = 1'b1;
                set_ch(p, 1'b1, pa[p], pd[p], pw[p]);
            end
            p = model_pick();
            wait_ack("rand", n);
            check("rand_ack", 32'(ack), 32'd1 << p);
            check("rand_grant", 32'(grant), 32'(p));
            if (pw[p]) check("rand_rdata", 32'(rdata), 32'(model_mem(pa[p])));
            else shadow[int'(pa[p])] = pd[p];
            pend[p] = 0;
            req[p] = 1'b0;
            last = p;
        end
        req = '0;
        repeat (8) step();
        for (int a = 0; a < 48; a++) begin
            check("rand_mem_lo", 32'(mem[17'(a)]), 32'(model_mem(17'(a))));
            check("rand_mem_hi", 32'(mem[17'(a) | 17'h1_0000]), 32'(model_mem(17'(a) | 17'h1_0000)));
        end

        check("strobes_never_both_low", 32'(both_low), 32'd0);
        check("we_low_only_with_data_oe", 32'(we_no_oe), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_bus_arbiter.md
Name: ram_bus_arbiter

Overview:
- Parametrised N-channel arbiter that serialises RAM accesses from several bus masters (CPU, SPI bridge, video fetch, future DMA) onto one external SRAM port.
- Generalises the fixed two-master CPU/SPI sharing in the current top into a configurable channel count.
- Adds selectable fixed-priority-channel-0 or pure round-robin arbitration and configurable strobe width.
- Sits between the master-side request logic in top and the RAM pins: ram_addr, ram_oe_n, ram_we_n, data bus.

Parameters:
- NUM_CH, 3, number of requesting channels (2..8).
- ADDR_WIDTH, 17, RAM address width.
- DATA_WIDTH, 8, data width.
- STROBE_CYCLES, 3, clocks ram_oe_n/ram_we_n held low (1..15).
- CH0_PRIORITY, 1, 1 = channel 0 always wins when requesting; 0 = pure round-robin.

Ports:
- clock_i  in  1  system clock (64 MHz)
- reset_i  in  1  synchronous active-high reset
- ch_req_i  in  NUM_CH  per-channel level request
- ch_addr_i  in  NUM_CH*ADDR_WIDTH  packed addresses, channel k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- ch_wdata_i  in  NUM_CH*DATA_WIDTH  packed write data
- ch_we_n_i  in  NUM_CH  per-channel write enable, active low
- ch_ack_o  out  NUM_CH  one-cycle completion pulse to the granted channel
- rdata_o  out  DATA_WIDTH  last captured read data, shared by all channels
- grant_o  out  $clog2(NUM_CH)  index of the current/last granted channel
- busy_o  out  1  high whenever state is not IDLE
- ram_addr_o  out  ADDR_WIDTH  registered RAM address
- ram_data_o  out  DATA_WIDTH  registered write data
- ram_data_oe_o  out  1  FPGA drives the data bus
- ram_data_i  in  DATA_WIDTH  RAM read data
- ram_oe_n_o  out  1  RAM output enable, active low
- ram_we_n_o  out  1  RAM write enable, active low

Behaviour:
- Reset values (sync, while reset_i high):
  - state = IDLE.
  - ram_oe_n_o = 1, ram_we_n_o = 1, ram_data_oe_o = 0.
  - ch_ack_o = 0, busy_o = 0.
  - ram_addr_o = 0, ram_data_o = 0, rdata_o = 0, grant_o = 0.
  - Round-robin pointer = NUM_CH-1, so channel 0 is searched first.
- FSM states: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
- IDLE:
  - If any ch_req_i is high, pick a winner, register its addr/wdata/we_n into ram_addr_o/ram_data_o/a we latch, set grant_o, go to SETUP.
  - Otherwise stay in IDLE.
- SETUP (1 cycle):
  - Address stable, both strobes high.
  - ram_data_oe_o = 1 if the latched we_n = 0.
- STROBE (STROBE_CYCLES cycles, counter-timed):
  - ram_we_n_o low for writes, ram_oe_n_o low for reads, never both.
  - For reads, ram_data_i is sampled into rdata_o on the clock edge that ends the last STROBE cycle.
- HOLD (1 cycle):
  - Strobes high; ram_data_oe_o stays asserted through HOLD for writes (data hold time).
  - ch_ack_o[grant] = 1 for exactly this cycle.
  - Round-robin pointer updated to the granted channel.
- Next state after HOLD is IDLE; ram_data_oe_o deasserts on entry to IDLE.
- Latency: request sampled high in IDLE at cycle 0 -> ack in cycle STROBE_CYCLES+2 (cycle 5 at default). Back-to-back throughput is one access per STROBE_CYCLES+3 clocks.
- Arbitration:
  - CH0_PRIORITY=1: ch_req_i[0] wins unconditionally. Otherwise the first requesting channel after the pointer, with wrap-around, wins.
  - CH0_PRIORITY=0: plain round-robin over all channels.
- Handshake rules:
  - Masters hold req/addr/wdata/we_n stable until ack, and drop req on the edge where ack is seen.
  - Inputs are latched in IDLE, so later changes do not affect the access in flight.
  - req dropped mid-access: the access still completes and ack still pulses.
  - req still high in the IDLE cycle after ack starts a new access (intended for bursts).
- Simultaneous requests in the same IDLE cycle: exactly one is granted; the others wait, with no lost request.
- Reset mid-access: next edge forces strobes high, data_oe low, no ack, IDLE. A partial write is tolerated by the system.
- The strobe counter width is $clog2(STROBE_CYCLES+1) and it does not wrap.

Decomposition:
- Package ram_bus_arbiter_pkg holds:
  - state_t enum (IDLE, SETUP, STROBE, HOLD).
  - Helper function ch_slice for packed-vector indexing.
- Sub-module rr_picker: combinational round-robin picker (req vector, pointer, CH0_PRIORITY) -> valid + index. It is unit-testable on its own and reused later for IRQ source arbitration.

Test Plan:
- Single read: ch1 req, addr 17'h0_4000, RAM holds 8'hA5 -> ram_oe_n_o low cycles 2-4, ch_ack_o=3'b010 at cycle 5, rdata_o=8'hA5, ram_we_n_o never low.
- Single write: ch2 writes 8'h01 to 17'h1_8000 -> ram_we_n_o low 3 cycles, ram_data_oe_o high SETUP..HOLD, mock_ram readback 8'h01.
- Contention with CH0_PRIORITY=1: ch0, ch1, ch2 all request continuously -> ch0 granted every slot while requesting. After ch0 drops, grants go 1,2,1,2.
- Round-robin (CH0_PRIORITY=0): all three request continuously -> grant_o sequence 0,1,2,0,1,2 and ack spacing of 6 cycles.
- Reset mid-strobe: assert reset_i in the 2nd STROBE cycle of a write -> next cycle ram_we_n_o=1, ram_data_oe_o=0, no ack, busy_o=0. A subsequent ch0 read completes normally.
- Parameter sweep: NUM_CH=8, STROBE_CYCLES=1 -> ack at cycle 3; channel 7 request is granted after wrap-around from pointer 6.
